// File: rtl/rssb_pkg.sv
// Shared types and constants for the RSSB sequencer and its datapath.
package rssb_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_PC_WIDTH = 8;

    localparam logic [7:0] OP_HALT        = 8'h00;
    localparam int         RAM_WINDOW_BIT = 7;

    typedef logic [DEF_WIDTH-1:0]    word_t;
    typedef logic [DEF_PC_WIDTH-1:0] pc_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        HALT
    } state_t;

endpackage

// File: rtl/rssb_sequencer_if.sv
// Program ROM and data RAM bus seen by the sequencer (master) and memories (slave).
interface rssb_sequencer_if #(
    parameter int WIDTH    = 8,
    parameter int PC_WIDTH = 8
);
    logic [PC_WIDTH-1:0] rom_addr;
    logic [WIDTH-1:0]    rom_data;
    logic [WIDTH-1:0]    mem_address;
    logic [WIDTH-1:0]    mem_wdata;
    logic                mem_write;
    logic [WIDTH-1:0]    mem_rdata;

    modport master (
        output rom_addr, mem_address, mem_wdata, mem_write,
        input  rom_data, mem_rdata
    );

    modport slave (
        input  rom_addr, mem_address, mem_wdata, mem_write,
        output rom_data, mem_rdata
    );
endinterface

// File: rtl/rssb_alu.sv
// Reverse subtract mem - acc on sign-extended operands; the extra bit is the borrow.
module rssb_alu #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] res,
    output logic             borrow
);
    logic [WIDTH:0] diff;

    // Borrow is the sign of the true difference, so 127 - (-1) wraps res without skipping.
    assign diff   = {mem_rdata[WIDTH-1], mem_rdata} - {acc[WIDTH-1], acc};
    assign res    = diff[WIDTH-1:0];
    assign borrow = diff[WIDTH];
endmodule

// File: rtl/rssb_sequencer.sv
// RSSB CPU sequencer: fetches operand addresses from ROM, subtracts, writes back and skips on borrow.
module rssb_sequencer
    import rssb_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PC_WIDTH = DEF_PC_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    rssb_sequencer_if.master  bus,
    output logic [WIDTH-1:0]  acc,
    output logic              busy,
    output logic              halted
);
    state_t              state, state_n;
    logic [PC_WIDTH-1:0] pc, pc_n;
    logic [WIDTH-1:0]    instr_q, instr_n;
    logic [WIDTH-1:0]    acc_n;
    logic [WIDTH-1:0]    res;
    logic                borrow;

    rssb_alu #(.WIDTH(WIDTH)) u_alu (
        .mem_rdata (bus.mem_rdata),
        .acc       (acc),
        .res       (res),
        .borrow    (borrow)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= '0;
            instr_q <= '0;
            acc     <= '0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            instr_q <= instr_n;
            acc     <= acc_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        instr_n       = instr_q;
        acc_n         = acc;
        bus.mem_write = 1'b0;
        unique case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_n = FETCH;
                    pc_n    = '0;
                    acc_n   = '0;
                end
            end
            FETCH: begin
                instr_n = bus.rom_data;
                state_n = EXEC;
            end
            EXEC: begin
                if (instr_q == WIDTH'(OP_HALT)) begin
                    state_n = HALT;
                end else if (!instr_q[RAM_WINDOW_BIT]) begin
                    pc_n    = pc + PC_WIDTH'(1);
                    state_n = FETCH;
                end else begin
                    // Write strobe is decoded from state, so an async reset drops it at once.
                    bus.mem_write = 1'b1;
                    acc_n         = res;
                    pc_n          = pc + (borrow ? PC_WIDTH'(2) : PC_WIDTH'(1));
                    state_n       = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.rom_addr    = pc;
    assign bus.mem_address = instr_q;
    assign bus.mem_wdata   = res;
    assign busy            = (state == FETCH) || (state == EXEC);
    assign halted          = (state == HALT);

endmodule

// File: tb/tb_rssb_sequencer.sv
// Directed bench for rssb_sequencer with an ISA-level scoreboard of executed instructions.
module tb_rssb_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] acc;
    logic       busy;
    logic       halted;

    rssb_sequencer_if #(.WIDTH(8), .PC_WIDTH(8)) bus ();

    rssb_sequencer #(.WIDTH(8), .PC_WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bus    (bus.master),
        .acc    (acc),
        .busy   (busy),
        .halted (halted)
    );

    always #5 clk = ~clk;

    logic [7:0] rom      [256];
    logic [7:0] ram      [4];
    logic [7:0] ram_init [4];

    assign bus.rom_data  = rom[bus.rom_addr];
    assign bus.mem_rdata = ram[bus.mem_address[1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                ram <= ram_init;
        else if (bus.mem_write) ram[bus.mem_address[1:0]] <= bus.mem_wdata;
    end

    typedef struct {
        logic [7:0] pc;
        logic [7:0] instr;
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] acc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] pc_hist[$];
    int         n_checks = 0;
    int         n_err    = 0;
    int         wr_count = 0;
    bit         acc_pending = 1'b0;
    logic [7:0] exp_acc;
    int         cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural model: walks the ROM against a copy of the RAM and queues one entry per instruction.
    task automatic model(input int n_max);
        logic [7:0] mram [4];
        logic [7:0] pc;
        logic [7:0] a;
        logic [7:0] ins;
        int         d;
        exp_t       e;
        mram = ram;
        pc   = 8'h00;
        a    = 8'h00;
        for (int k = 0; k < n_max; k++) begin
            ins     = rom[pc];
            e.pc    = pc;
            e.instr = ins;
            e.wr    = 1'b0;
            e.wdata = 8'h00;
            if (ins == 8'h00) begin
                e.acc = a;
                sb.push_back(e);
                break;
            end
            if (ins[7]) begin
                d             = int'($signed(mram[ins[1:0]])) - int'($signed(a));
                a             = 8'(d);
                mram[ins[1:0]] = a;
                e.wr          = 1'b1;
                e.wdata       = a;
                pc            = pc + ((d < 0) ? 8'd2 : 8'd1);
            end else begin
                pc = pc + 8'd1;
            end
            e.acc = a;
            sb.push_back(e);
        end
    endtask

    task automatic monitor();
        bit   phase = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                phase = 1'b0;
                continue;
            end
            if (acc_pending) begin
                check("acc_after_exec", 32'(acc), 32'(exp_acc));
                acc_pending = 1'b0;
            end
            if (!busy) begin
                phase = 1'b0;
            end else begin
                if (phase) begin
                    check("rom_addr_known", 32'($isunknown(bus.rom_addr)), 32'd0);
                    if (sb.size() == 0) begin
                        check("unexpected_exec", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check("pc", 32'(bus.rom_addr), 32'(e.pc));
                        check("instr", 32'(bus.mem_address), 32'(e.instr));
                        check("mem_write", 32'(bus.mem_write), 32'(e.wr));
                        if (e.wr) check("mem_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
                        exp_acc     = e.acc;
                        acc_pending = 1'b1;
                    end
                    pc_hist.push_back(bus.rom_addr);
                    if (bus.mem_write) wr_count++;
                end
                phase = !phase;
            end
        end
    endtask

    task automatic clear_tracking();
        sb.delete();
        pc_hist.delete();
        acc_pending = 1'b0;
        wr_count    = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_tracking();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_rom(input logic [7:0] fill);
        for (int i = 0; i < 256; i++) rom[i] = fill;
    endtask

    task automatic run_program(input int n_max, input bit extra_start, input bit expect_halt,
                               output int cycles);
        pc_hist.delete();
        wr_count = 0;
        model(n_max);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = extra_start;
        check("fetch_pc0", 32'(bus.rom_addr), 32'd0);
        check("fetch_acc0", 32'(acc), 32'd0);
        check("fetch_busy", 32'(busy), 32'd1);
        cycles = 0;
        if (expect_halt) begin
            while (!halted && cycles < 1000) begin
                @(posedge clk);
                cycles++;
                @(negedge clk);
                #1;
                if (cycles >= 3) start = 1'b0;
            end
            start = 1'b0;
            check("halted", 32'(halted), 32'd1);
        end else begin
            while ((sb.size() != 0 || acc_pending) && cycles < 2000) begin
                @(posedge clk);
                cycles++;
                @(negedge clk);
                #1;
            end
            start = 1'b0;
        end
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        rst      = 1'b1;
        start    = 1'b0;
        ram_init = '{8'h01, 8'h02, 8'h08, 8'h04};
        load_rom(8'h00);

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("rst_mem_address", 32'(bus.mem_address), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_mem_write", 32'(bus.mem_write), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        rst = 1'b0;

        // Basic program
        rom[0] = 8'h80; rom[1] = 8'h81; rom[2] = 8'h00;
        run_program(16, 1'b0, 1'b1, cyc);
        check("basic_cycles", 32'(cyc), 32'd6);
        check("basic_acc", 32'(acc), 32'd1);
        check("basic_ram80", 32'(ram[0]), 32'd1);
        check("basic_ram81", 32'(ram[1]), 32'd1);
        check("basic_pc", 32'(bus.rom_addr), 32'd2);
        check("basic_writes", 32'(wr_count), 32'd2);

        // HALT holds pc and acc
        repeat (2) begin
            @(negedge clk);
            check("halt_hold_acc", 32'(acc), 32'd1);
            check("halt_hold_pc", 32'(bus.rom_addr), 32'd2);
            check("halt_hold_busy", 32'(busy), 32'd0);
        end

        // Restart from HALT, with extra start pulses during FETCH/EXEC; RAM keeps its values
        run_program(16, 1'b1, 1'b1, cyc);
        check("restart_cycles", 32'(cyc), 32'd6);
        check("restart_ram81", 32'(ram[1]), 32'd0);
        check("restart_acc", 32'(acc), 32'd0);
        check("restart_pc", 32'(bus.rom_addr), 32'd2);

        // Skip on borrow
        do_reset();
        load_rom(8'h00);
        rom[0] = 8'h82; rom[1] = 8'h80; rom[2] = 8'h83; rom[3] = 8'h00;
        run_program(16, 1'b0, 1'b1, cyc);
        check("skip_cycles", 32'(cyc), 32'd6);
        check("skip_ram80", 32'(ram[0]), 32'hF9);
        check("skip_acc", 32'(acc), 32'hF9);
        check("skip_ram82", 32'(ram[2]), 32'd8);
        check("skip_ram83", 32'(ram[3]), 32'd4);
        check("skip_writes", 32'(wr_count), 32'd2);
        check("skip_pc_after_borrow", 32'(pc_hist[2]), 32'd3);

        // Overflow: acc=-1 from [0x80]=0xFF (skips pc 1), then 0x7F - (-1) = 0x80 without skip
        ram_init = '{8'hFF, 8'h7F, 8'h08, 8'h04};
        do_reset();
        load_rom(8'h00);
        rom[0] = 8'h80; rom[1] = 8'h01; rom[2] = 8'h81; rom[3] = 8'h01; rom[4] = 8'h00;
        run_program(16, 1'b0, 1'b1, cyc);
        check("ovf_ram81", 32'(ram[1]), 32'h80);
        check("ovf_acc", 32'(acc), 32'h80);
        check("ovf_pc_of_81", 32'(pc_hist[1]), 32'd2);
        check("ovf_no_skip", 32'(pc_hist[2]), 32'd3);
        check("ovf_final_pc", 32'(bus.rom_addr), 32'd4);
        ram_init = '{8'h01, 8'h02, 8'h08, 8'h04};

        // PC wrap: borrow at pc=0xFF lands on 0x01
        do_reset();
        load_rom(8'h01);
        rom[8'hFE] = 8'h82;
        rom[8'hFF] = 8'h80;
        run_program(257, 1'b0, 1'b0, cyc);
        check("wrap_hist_len", 32'(pc_hist.size()), 32'd257);
        check("wrap_pc_fe", 32'(pc_hist[254]), 32'hFE);
        check("wrap_pc_ff", 32'(pc_hist[255]), 32'hFF);
        check("wrap_pc_01", 32'(pc_hist[256]), 32'h01);
        do_reset();

        // Asynchronous reset during EXEC of 0x82 (acc=1, so a stray write would store 7)
        load_rom(8'h00);
        rom[0] = 8'h80; rom[1] = 8'h82; rom[2] = 8'h00;
        model(16);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(bus.mem_write === 1'b1 && bus.mem_address === 8'h82) && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("midexec_found", 32'(bus.mem_address), 32'h82);
        #1 rst = 1'b1;
        #1;
        check("midexec_mem_write", 32'(bus.mem_write), 32'd0);
        check("midexec_busy", 32'(busy), 32'd0);
        check("midexec_acc", 32'(acc), 32'd0);
        check("midexec_pc", 32'(bus.rom_addr), 32'd0);
        rst = 1'b0;
        clear_tracking();
        @(posedge clk);
        #1;
        check("midexec_ram82", 32'(ram[2]), 32'd8);
        check("midexec_idle_busy", 32'(busy), 32'd0);
        check("midexec_idle_halted", 32'(halted), 32'd0);
        check("midexec_idle_pc", 32'(bus.rom_addr), 32'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
